// File: rtl/i2c_fifo.sv
// Single-clock DEPTH x 1-bit FIFO for buffering serial I2C address/data bits.
// Registered read data, plus one-cycle overflow/underflow pulses for rejected requests.
module i2c_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic          addr_data,
    output logic          data_out,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             data_out_q, data_out_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_ok, rd_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

    // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
    assign wr_ok = wr_en && (!full || rd_en);
    assign rd_ok = rd_en && !empty;

    always_comb begin
        mem_d       = mem_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        overflow_d  = wr_en && !wr_ok;
        underflow_d = rd_en && !rd_ok;

        if (wr_ok) begin
            mem_d[wptr_q] = addr_data;
            wptr_d        = wptr_q + AW'(1);
        end

        if (rd_ok) begin
            data_out_d = mem_q[rptr_q];
            rptr_d     = rptr_q + AW'(1);
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            data_out_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign data_out  = data_out_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_i2c_fifo.sv
// Bench for i2c_fifo: directed scenarios then random traffic, all checked every cycle
// against a queue-based reference model.
module tb_i2c_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic          addr_data;
    logic          data_out;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model state
    bit q_m[$];
    bit dout_m = 1'b0;
    bit ovf_m  = 1'b0;
    bit unf_m  = 1'b0;

    i2c_fifo #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr_data(addr_data),
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the model by the FIFO rules, then compare.
    task automatic step(input bit r_st, input bit w, input bit r, input bit d);
        bit was_full, was_empty, w_acc, r_acc;
        rst       = r_st;
        wr_en     = w;
        rd_en     = r;
        addr_data = d;
        was_full  = (q_m.size() == DEPTH);
        was_empty = (q_m.size() == 0);
        if (r_st) begin
            q_m.delete();
            dout_m = 1'b0;
            ovf_m  = 1'b0;
            unf_m  = 1'b0;
        end else begin
            w_acc = w && (!was_full || r);
            r_acc = r && !was_empty;
            if (r_acc) dout_m = q_m.pop_front();
            if (w_acc) q_m.push_back(d);
            ovf_m = w && !w_acc;
            unf_m = r && !r_acc;
        end
        @(posedge clk);
        #1;
        cyc++;
        check("count",     32'(count),     32'(q_m.size()));
        check("empty",     32'(empty),     32'(q_m.size() == 0));
        check("full",      32'(full),      32'(q_m.size() == DEPTH));
        check("data_out",  32'(data_out),  32'(dout_m));
        check("overflow",  32'(overflow),  32'(ovf_m));
        check("underflow", 32'(underflow), 32'(unf_m));
    endtask

    initial begin
        bit pattern [5];
        int pw, pr;
        pattern = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr_data = 1'b0;

        // Reset for two cycles
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // Ordered write/read of a short pattern
        for (int i = 0; i < 5; i++) step(0, 1, 0, pattern[i]);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0);
            check("pattern_out", 32'(data_out), 32'(pattern[i]));
        end

        // Fill with ones, overflow attempt with a zero, drain
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        check("ovf_pulse", 32'(overflow), 32'd1);
        step(0, 0, 0, 0);
        check("ovf_clear", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);
        check("drain_last", 32'(data_out), 32'd1);

        // Underflow from empty, then simultaneous read/write on empty
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 1, 1, 1);
        check("empty_rw_cnt", 32'(count), 32'd1);
        step(0, 0, 1, 0);

        // Full with simultaneous read/write across pointer wrap
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 1'(i));
        for (int i = 0; i < 20; i++) step(0, 1, 1, 1'(i + 1));
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);

        // Reset mid-operation with a concurrent write
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        step(1, 1, 0, 1);
        step(0, 1, 0, 1);
        step(0, 0, 1, 0);
        check("post_rst_bit", 32'(data_out), 32'd1);

        // Random traffic: write-heavy, then read-heavy, with rare resets
        for (int i = 0; i < 600; i++) begin
            pw = (i < 300) ? 70 : 35;
            pr = (i < 300) ? 40 : 65;
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < pw),
                 ($urandom_range(0, 99) < pr),
                 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
